// File: rtl/fir_mac_sequencer_if.sv
// Sample/output/coefficient/multiplier-cell bundle for fir_mac_sequencer.
// master: environment side (source, coef loader, multiplier cell); slave: sequencer side.
interface fir_mac_sequencer_if #(
    parameter int AW    = 4,
    parameter int OUT_W = 24
);
    logic signed [17:0]      din;
    logic                    din_valid;
    logic                    din_ready;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_valid;
    logic                    coef_wr_en;
    logic [AW-1:0]           coef_wr_addr;
    logic signed [24:0]      coef_wr_data;
    logic                    coef_wr_err;
    logic                    cell_valid_in;
    logic signed [24:0]      cell_coef;
    logic signed [17:0]      cell_sample;
    logic signed [47:0]      cell_result;
    logic                    cell_valid_out;

    modport master (
        output din, din_valid, coef_wr_en, coef_wr_addr, coef_wr_data,
        output cell_result, cell_valid_out,
        input  din_ready, dout, dout_valid, coef_wr_err,
        input  cell_valid_in, cell_coef, cell_sample
    );

    modport slave (
        input  din, din_valid, coef_wr_en, coef_wr_addr, coef_wr_data,
        input  cell_result, cell_valid_out,
        output din_ready, dout, dout_valid, coef_wr_err,
        output cell_valid_in, cell_coef, cell_sample
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller driving one external 2-stage multiplier cell.
// Ports: clk, reset (sync, active-high), bus (fir_mac_sequencer_if.slave):
//   din/din_valid/din_ready sample in, dout/dout_valid filtered out,
//   coef_wr_* coefficient loader with coef_wr_err, cell_* multiplier cell link.
// Option: define FIR_SEQ_SAT_EN to clamp the output instead of wrapping it.
module fir_mac_sequencer #(
    parameter int NTAPS = 16,
    parameter int AW    = 4,
    parameter int OUT_W = 24,
    parameter int SHIFT = 23
) (
    input  logic               clk,
    input  logic               reset,
    fir_mac_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   NT   = (AW+1)'(NTAPS);
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

`ifdef FIR_SEQ_SAT_EN
    localparam logic signed [47:0] SMAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
    localparam logic signed [47:0] SMIN = -SMAX - 48'sd1;
`endif

    state_t state;
    state_t state_nxt;

    logic signed [17:0] line [NTAPS];
    logic signed [24:0] coef [NTAPS];

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      newest;
    logic [AW-1:0]      iss_cnt;
    logic [AW:0]        rcv_cnt;
    logic signed [47:0] acc;

    logic                    cvi_q;
    logic signed [24:0]      coef_q;
    logic signed [17:0]      samp_q;
    logic signed [OUT_W-1:0] dout_q;
    logic                    dv_q;
    logic                    err_q;

    logic                    cvi_d;
    logic signed [24:0]      coef_d;
    logic signed [17:0]      samp_d;
    logic                    dv_d;

    logic                    accept;
    logic                    coef_ok;
    logic                    coef_we;
    logic                    iss_last;
    logic [AW-1:0]           tap_nxt;
    logic                    acc_en;
    logic signed [47:0]      acc_nxt;
    logic [AW:0]             rcv_nxt;

    // Delay-line slot holding the sample k taps older than base.
    function automatic logic [AW-1:0] tap_idx(
        input logic [AW-1:0] base,
        input logic [AW-1:0] k
    );
        logic [AW:0] t;
        t = {1'b0, base} + NT - {1'b0, k};
        if (t >= NT) t = t - NT;
        return t[AW-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] scale(
        input logic signed [47:0] a
    );
`ifdef FIR_SEQ_SAT_EN
        logic signed [47:0] s;
        s = a >>> SHIFT;
        if (s > SMAX) s = SMAX;
        else if (s < SMIN) s = SMIN;
        return s[OUT_W-1:0];
`else
        return OUT_W'(a >>> SHIFT);
`endif
    endfunction

    assign accept   = (state == IDLE) && bus.din_valid;
    assign coef_ok  = (state == IDLE) && ({1'b0, bus.coef_wr_addr} < NT);
    assign coef_we  = bus.coef_wr_en && coef_ok;
    assign iss_last = (iss_cnt == LAST);
    assign tap_nxt  = iss_cnt + AW'(1);

    // Results start returning while taps are still being issued,
    // so accumulation is open in both RUN and DRAIN.
    assign acc_en  = ((state == RUN) || (state == DRAIN))
                   && bus.cell_valid_out && (rcv_cnt < NT);
    assign acc_nxt = acc_en ? acc + bus.cell_result : acc;
    assign rcv_nxt = acc_en ? rcv_cnt + (AW+1)'(1) : rcv_cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (iss_last) state_nxt = DRAIN;
            DRAIN:   if (rcv_nxt == NT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered cell/output signals.
    always_comb begin
        cvi_d  = 1'b0;
        coef_d = '0;
        samp_d = '0;
        dv_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    // Tap 0 is the incoming sample itself; a same-cycle
                    // write to coef[0] must already apply to it.
                    cvi_d  = 1'b1;
                    samp_d = bus.din;
                    if (coef_we && (bus.coef_wr_addr == '0))
                        coef_d = bus.coef_wr_data;
                    else
                        coef_d = coef[0];
                end
            end
            RUN: begin
                if (!iss_last) begin
                    cvi_d  = 1'b1;
                    samp_d = line[tap_idx(newest, tap_nxt)];
                    coef_d = coef[tap_nxt];
                end
            end
            DRAIN:   dv_d = (state_nxt == DONE);
            DONE:    dv_d = 1'b0;
            default: dv_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                line[i] <= '0;
                coef[i] <= '0;
            end
            wr_ptr  <= '0;
            newest  <= '0;
            iss_cnt <= '0;
            rcv_cnt <= '0;
            acc     <= '0;
            cvi_q   <= 1'b0;
            coef_q  <= '0;
            samp_q  <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (coef_we) coef[bus.coef_wr_addr] <= bus.coef_wr_data;
            if (accept) begin
                line[wr_ptr] <= bus.din;
                newest       <= wr_ptr;
                wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
                iss_cnt      <= '0;
                rcv_cnt      <= '0;
                acc          <= '0;
            end else begin
                if ((state == RUN) && !iss_last) iss_cnt <= tap_nxt;
                acc     <= acc_nxt;
                rcv_cnt <= rcv_nxt;
            end
            cvi_q  <= cvi_d;
            coef_q <= coef_d;
            samp_q <= samp_d;
            dv_q   <= dv_d;
            if (dv_d) dout_q <= scale(acc_nxt);
            err_q  <= bus.coef_wr_en && !coef_ok;
        end
    end

    assign bus.din_ready     = (state == IDLE);
    assign bus.dout          = dout_q;
    assign bus.dout_valid    = dv_q;
    assign bus.coef_wr_err   = err_q;
    assign bus.cell_valid_in = cvi_q;
    assign bus.cell_coef     = coef_q;
    assign bus.cell_sample   = samp_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer with a 2-stage multiplier cell model
// and a sum-of-products reference model over the last NTAPS samples.
module tb_fir_mac_sequencer;
    localparam int NTAPS = 16;
    localparam int AW    = 5;
    localparam int OUT_W = 24;
    localparam int SHIFT = 0;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.AW(AW), .OUT_W(OUT_W)) bus ();

    fir_mac_sequencer #(
        .NTAPS(NTAPS), .AW(AW), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Multiplier cell: result two cycles after issue, not reset.
    logic               v1 = 1'b0;
    logic signed [47:0] p1 = '0;
    always @(posedge clk) begin
        v1 <= bus.cell_valid_in;
        p1 <= 48'(longint'(bus.cell_coef) * longint'(bus.cell_sample));
        bus.cell_valid_out <= v1;
        bus.cell_result    <= p1;
    end

    // Reference model: history newest-first and the coefficient bank.
    int m_hist [NTAPS];
    int m_coef [NTAPS];

    function automatic void m_reset();
        for (int i = 0; i < NTAPS; i++) begin
            m_hist[i] = 0;
            m_coef[i] = 0;
        end
    endfunction

    function automatic void m_accept(input int d);
        for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = d;
    endfunction

    function automatic logic signed [OUT_W-1:0] m_expect();
        longint s = 0;
        logic signed [47:0] a;
        longint sh;
        longint lim;
        for (int k = 0; k < NTAPS; k++)
            s += longint'(m_coef[k]) * longint'(m_hist[k]);
        a   = s[47:0];
        sh  = longint'(a) >>> SHIFT;
        lim = longint'(1) << (OUT_W - 1);
`ifdef FIR_SEQ_SAT_EN
        if (sh > lim - 1) sh = lim - 1;
        else if (sh < -lim) sh = -lim;
`endif
        return sh[OUT_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.din          = '0;
        bus.din_valid    = 1'b0;
        bus.coef_wr_en   = 1'b0;
        bus.coef_wr_addr = '0;
        bus.coef_wr_data = '0;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        m_reset();
    endtask

    task automatic write_coef(input int addr, input logic signed [24:0] data,
                              output logic err);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = AW'(addr);
        bus.coef_wr_data = data;
        tick();
        bus.coef_wr_en = 1'b0;
        err = bus.coef_wr_err;
    endtask

    // Offer one sample and observe its output; no checking here.
    task automatic send(input int d, output logic signed [OUT_W-1:0] got,
                        output int lat, output int cvi, output bit ok);
        int w = 0;
        while (!bus.din_ready && w < 50) begin
            tick();
            w++;
        end
        bus.din       = 18'(d);
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        lat = 1;
        cvi = 0;
        ok  = 1'b0;
        while (lat < 60) begin
            if (bus.dout_valid) begin
                ok = 1'b1;
                break;
            end
            cvi += int'(bus.cell_valid_in);
            tick();
            lat++;
        end
        got = bus.dout;
    endtask

    task automatic load_random_coefs();
        logic e;
        logic signed [24:0] r;
        for (int k = 0; k < NTAPS; k++) begin
            r = 25'($urandom);
            write_coef(k, r, e);
            m_coef[k] = int'(r);
        end
    endtask

    task automatic test_reset();
        logic signed [OUT_W-1:0] got;
        int lat, cvi;
        bit ok;
        load_random_coefs();
        m_accept(12345);
        send(12345, got, lat, cvi, ok);
        bus.din       = 18'sd999;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.din_ready !== 1'b1)
            $display("FAIL rst_din_ready: got %0b expected 1", bus.din_ready);
        if (bus.din_ready !== 1'b1) errors++;
        checks++;
        if (bus.dout !== '0) begin
            $display("FAIL rst_dout: got %0d expected 0", bus.dout);
            errors++;
        end
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            $display("FAIL rst_dout_valid: got %0b expected 0", bus.dout_valid);
            errors++;
        end
        checks++;
        if (bus.coef_wr_err !== 1'b0) begin
            $display("FAIL rst_coef_wr_err: got %0b expected 0", bus.coef_wr_err);
            errors++;
        end
        checks++;
        if (bus.cell_valid_in !== 1'b0) begin
            $display("FAIL rst_cell_valid_in: got %0b expected 0", bus.cell_valid_in);
            errors++;
        end
        checks++;
        if (bus.cell_coef !== '0) begin
            $display("FAIL rst_cell_coef: got %0d expected 0", bus.cell_coef);
            errors++;
        end
        checks++;
        if (bus.cell_sample !== '0) begin
            $display("FAIL rst_cell_sample: got %0d expected 0", bus.cell_sample);
            errors++;
        end
        reset = 1'b0;
        m_reset();
        checks++;
        if (bus.din_ready !== 1'b1) begin
            $display("FAIL rst_ready_after: got %0b expected 1", bus.din_ready);
            errors++;
        end
    endtask

    task automatic test_impulse();
        logic signed [OUT_W-1:0] got, exp;
        int lat, cvi, nerr, d;
        bit ok;
        logic e;
        do_reset(2);
        nerr = 0;
        for (int k = 0; k < NTAPS; k++) begin
            write_coef(k, 25'(k + 1), e);
            m_coef[k] = k + 1;
            nerr += int'(e);
        end
        checks++;
        if (nerr !== 0) begin
            $display("FAIL imp_wr_err: got %0d errs expected 0", nerr);
            errors++;
        end
        for (int i = 0; i < NTAPS + 2; i++) begin
            d = (i == 0) ? 1 : 0;
            m_accept(d);
            exp = m_expect();
            send(d, got, lat, cvi, ok);
            checks++;
            if (!ok) begin
                $display("FAIL imp_timeout: sample %0d got none expected dout_valid", i);
                errors++;
            end else if (got !== exp) begin
                $display("FAIL imp_dout: sample %0d got %0d expected %0d", i, got, exp);
                errors++;
            end
            checks++;
            if (lat !== NTAPS + 3) begin
                $display("FAIL imp_latency: sample %0d got %0d expected %0d", i, lat, NTAPS + 3);
                errors++;
            end
        end
    endtask

    task automatic test_dc();
        logic signed [OUT_W-1:0] got, exp;
        int lat, cvi;
        bit ok;
        logic e;
        do_reset(2);
        for (int k = 0; k < NTAPS; k++) begin
            write_coef(k, 25'sd1, e);
            m_coef[k] = 1;
        end
        for (int i = 0; i < NTAPS; i++) begin
            m_accept(100);
            exp = m_expect();
            send(100, got, lat, cvi, ok);
            checks++;
            if (!ok || got !== exp) begin
                $display("FAIL dc_dout: sample %0d got %0d expected %0d", i, got, exp);
                errors++;
            end
            checks++;
            if (cvi !== NTAPS) begin
                $display("FAIL dc_issue_count: sample %0d got %0d expected %0d", i, cvi, NTAPS);
                errors++;
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [OUT_W-1:0] got, exp;
        int lat, cvi;
        bit ok;
        logic e;
        do_reset(2);
        for (int k = 0; k < NTAPS; k++) begin
            write_coef(k, 25'sd16777215, e);
            m_coef[k] = 16777215;
        end
        for (int i = 0; i < NTAPS; i++) begin
            m_accept(131071);
            exp = m_expect();
            send(131071, got, lat, cvi, ok);
            checks++;
            if (!ok || got !== exp) begin
                $display("FAIL sat_dout: sample %0d got %0h expected %0h", i, got, exp);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        logic signed [OUT_W-1:0] got, exp;
        logic signed [17:0] r;
        int lat, cvi;
        bit ok;
        do_reset(2);
        load_random_coefs();
        for (int i = 0; i < 20; i++) begin
            r = 18'($urandom);
            m_accept(int'(r));
            exp = m_expect();
            send(int'(r), got, lat, cvi, ok);
            checks++;
            if (!ok || got !== exp) begin
                $display("FAIL rand_dout: sample %0d got %0d expected %0d", i, got, exp);
                errors++;
            end
            checks++;
            if (lat !== NTAPS + 3) begin
                $display("FAIL rand_latency: sample %0d got %0d expected %0d", i, lat, NTAPS + 3);
                errors++;
            end
        end
    endtask

    task automatic test_abort();
        logic signed [OUT_W-1:0] exp;
        int pulses, w;
        logic e;
        do_reset(2);
        load_random_coefs();
        bus.din       = 18'sd5000;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (bus.cell_valid_in !== 1'b1) begin
            $display("FAIL abort_in_run: got %0b expected 1", bus.cell_valid_in);
            errors++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        checks++;
        if (bus.din_ready !== 1'b1) begin
            $display("FAIL abort_ready: got %0b expected 1", bus.din_ready);
            errors++;
        end
        pulses = 0;
        repeat (25) begin
            pulses += int'(bus.dout_valid);
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            $display("FAIL abort_dout_valid: got %0d pulses expected 0", pulses);
            errors++;
        end
        // Coefficient write and sample accept in the same cycle.
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = '0;
        bus.coef_wr_data = 25'sd1;
        bus.din          = 18'sd7;
        bus.din_valid    = 1'b1;
        m_coef[0] = 1;
        m_accept(7);
        exp = m_expect();
        tick();
        bus.coef_wr_en = 1'b0;
        bus.din_valid  = 1'b0;
        e = bus.coef_wr_err;
        checks++;
        if (e !== 1'b0) begin
            $display("FAIL abort_wr_err: got %0b expected 0", e);
            errors++;
        end
        w = 0;
        while (!bus.dout_valid && w < 60) begin
            tick();
            w++;
        end
        checks++;
        if (!bus.dout_valid || bus.dout !== exp) begin
            $display("FAIL abort_dout: got %0d expected %0d", bus.dout, exp);
            errors++;
        end
    endtask

    task automatic test_busy();
        logic signed [OUT_W-1:0] exp_q [$];
        logic signed [OUT_W-1:0] exp;
        logic e;
        int cyc, last, sent, nout;
        bit acc_now, wr_now;
        do_reset(2);
        load_random_coefs();
        write_coef(NTAPS, 25'($urandom), e);
        checks++;
        if (e !== 1'b1) begin
            $display("FAIL busy_addr_err: got %0b expected 1", e);
            errors++;
        end
        tick();
        checks++;
        if (bus.coef_wr_err !== 1'b0) begin
            $display("FAIL busy_err_pulse: got %0b expected 0", bus.coef_wr_err);
            errors++;
        end
        cyc  = 0;
        last = -100;
        sent = 0;
        nout = 0;
        bus.din       = 18'($urandom);
        bus.din_valid = 1'b1;
        while (cyc < 200 && nout < 3) begin
            acc_now = bus.din_ready && bus.din_valid;
            wr_now  = 1'b0;
            if (acc_now) begin
                m_accept(int'(bus.din));
                exp_q.push_back(m_expect());
                if (sent > 0) begin
                    checks++;
                    if (cyc - last !== NTAPS + 4) begin
                        $display("FAIL busy_interval: got %0d expected %0d", cyc - last, NTAPS + 4);
                        errors++;
                    end
                end
                last = cyc;
                sent++;
            end else if (cyc - last == 5) begin
                bus.coef_wr_en   = 1'b1;
                bus.coef_wr_addr = AW'($urandom_range(0, NTAPS - 1));
                bus.coef_wr_data = 25'($urandom);
                wr_now = 1'b1;
            end
            tick();
            cyc++;
            if (wr_now) begin
                bus.coef_wr_en = 1'b0;
                checks++;
                if (bus.coef_wr_err !== 1'b1) begin
                    $display("FAIL busy_run_err: got %0b expected 1", bus.coef_wr_err);
                    errors++;
                end
            end
            if (acc_now) begin
                if (sent == 3) bus.din_valid = 1'b0;
                else bus.din = 18'($urandom);
            end
            if (bus.dout_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (bus.dout !== exp) begin
                    $display("FAIL busy_dout: got %0d expected %0d", bus.dout, exp);
                    errors++;
                end
                nout++;
            end
        end
        bus.din_valid = 1'b0;
        checks++;
        if (nout !== 3 || sent !== 3) begin
            $display("FAIL busy_count: got %0d outputs %0d accepts expected 3", nout, sent);
            errors++;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_reset();
        do_reset(3);
        test_reset();
        test_impulse();
        test_dc();
        test_saturation();
        test_random();
        test_abort();
        test_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
